// File: rtl/rtc_bus_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_pkg
//  Description : Shared types and default timing constants for the RTC
//                parallel-bus write engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

  // Width of the multiplexed address/data bus
  localparam int AD_W = 8;

  // Default phase lengths in clock cycles
  localparam int T_SETUP_D = 2;
  localparam int T_PULSE_D = 4;
  localparam int T_HOLD_D  = 2;
  localparam int T_GAP_D   = 3;

  // Write-cycle states; explicit 4-bit encoding so unused codes are known
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_GAP      = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rtc_bus_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_writer_if
//  Description : Sequencer request/advance handshake plus the RTC parallel
//                bus pins driven by the write engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_writer_if;
  import rtc_bus_pkg::*;

  logic            escriba;
  logic [AD_W-1:0] direc;
  logic [AD_W-1:0] dato;
  logic            siga;
  logic            cs_n;
  logic            rd_n;
  logic            wr_n;
  logic            a_d;
  logic [AD_W-1:0] ad_out;
  logic            ad_oe;
  logic            busy;

  // Write engine side
  modport master (
    input  escriba, direc, dato,
    output siga, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe, busy
  );

  // Sequencer / observer side
  modport slave (
    output escriba, direc, dato,
    input  siga, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe, busy
  );

endinterface
`default_nettype wire

// File: rtl/rtc_bus_writer_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_phase_timer
//  Description : Loadable down-counter timing one bus phase. A load value of
//                zero is stretched to one cycle. expire is high on the last
//                cycle of the phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (value == '0) ? CNT_W'(1) : value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign expire = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/rtc_bus_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_writer
//  Description : Executes one multiplexed address/data write cycle on the RTC
//                parallel bus per escriba request and returns the siga
//                advance handshake. Write-only: rd_n is held high.
//                Optional macro RTC_WR_CNT_EN adds the n_escrituras counter
//                of completed writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_writer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_D,
  parameter int T_PULSE = T_PULSE_D,
  parameter int T_HOLD  = T_HOLD_D,
  parameter int T_GAP   = T_GAP_D,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_writer_if.master   bus
`ifdef RTC_WR_CNT_EN
  ,
  output logic [7:0]         n_escrituras
`endif
);

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(T_PULSE);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD);
  localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(T_GAP);

  state_t           r_state;
  state_t           w_next;
  logic [AD_W-1:0]  r_data;
  logic             w_expire;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  rtc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .value  (w_load_val),
    .expire (w_expire)
  );

  // Next-state: timed phases advance on timer expiry, DONE lasts one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (bus.escriba) w_next = ST_A_SETUP;
      ST_A_SETUP:  if (w_expire)    w_next = ST_A_STROBE;
      ST_A_STROBE: if (w_expire)    w_next = ST_A_HOLD;
      ST_A_HOLD:   if (w_expire)    w_next = ST_GAP;
      ST_GAP:      if (w_expire)    w_next = ST_D_SETUP;
      ST_D_SETUP:  if (w_expire)    w_next = ST_D_STROBE;
      ST_D_STROBE: if (w_expire)    w_next = ST_D_HOLD;
      ST_D_HOLD:   if (w_expire)    w_next = ST_DONE;
      ST_DONE:                      w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // Timer reloads with the length of whichever phase is being entered
  always_comb begin
    w_load = (w_next != r_state);
    case (w_next)
      ST_A_SETUP, ST_D_SETUP:   w_load_val = C_SETUP;
      ST_A_STROBE, ST_D_STROBE: w_load_val = C_PULSE;
      ST_A_HOLD, ST_D_HOLD:     w_load_val = C_HOLD;
      ST_GAP:                   w_load_val = C_GAP;
      default:                  w_load_val = '0;
    endcase
  end

  // State register with bus pins decoded from the state being entered
  // ad_out itself holds the address, so only the data byte is latched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      bus.cs_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.a_d    <= 1'b0;
      bus.ad_out <= '0;
      bus.ad_oe  <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      bus.busy <= (w_next != ST_IDLE);
      if (r_state == ST_IDLE && bus.escriba) begin
        r_data <= bus.dato;
      end
      bus.cs_n  <= 1'b1;
      bus.wr_n  <= 1'b1;
      bus.a_d   <= 1'b0;
      bus.ad_oe <= 1'b0;
      case (w_next)
        ST_A_SETUP: begin
          bus.cs_n   <= 1'b0;
          bus.ad_oe  <= 1'b1;
          bus.ad_out <= bus.direc;
        end
        ST_A_STROBE: begin
          bus.cs_n  <= 1'b0;
          bus.ad_oe <= 1'b1;
          bus.wr_n  <= 1'b0;
        end
        ST_A_HOLD: begin
          bus.cs_n  <= 1'b0;
          bus.ad_oe <= 1'b1;
        end
        ST_D_SETUP: begin
          bus.cs_n   <= 1'b0;
          bus.ad_oe  <= 1'b1;
          bus.a_d    <= 1'b1;
          bus.ad_out <= r_data;
        end
        ST_D_STROBE: begin
          bus.cs_n  <= 1'b0;
          bus.ad_oe <= 1'b1;
          bus.a_d   <= 1'b1;
          bus.wr_n  <= 1'b0;
        end
        ST_D_HOLD: begin
          bus.cs_n  <= 1'b0;
          bus.ad_oe <= 1'b1;
          bus.a_d   <= 1'b1;
        end
        default: begin
          bus.cs_n <= 1'b1;
        end
      endcase
    end
  end

  // Advance handshake: echo the request in IDLE, release in DONE
  always_comb begin
    case (r_state)
      ST_IDLE: bus.siga = bus.escriba;
      ST_DONE: bus.siga = 1'b0;
      default: bus.siga = 1'b1;
    endcase
  end

  assign bus.rd_n = 1'b1;

`ifdef RTC_WR_CNT_EN
  // Count completed writes, wrapping modulo 256
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_escrituras <= 8'h00;
    end else if (r_state == ST_DONE) begin
      n_escrituras <= n_escrituras + 8'h01;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_writer
//  Description : Self-checking bench for rtc_bus_writer. A queue-based model
//                expands each accepted pair into its expected per-cycle bus
//                trace; directed tests pin timing, ordering, reset abort and
//                request drop. A second instance uses T_PULSE=0, T_GAP=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_writer;
  import rtc_bus_pkg::*;

  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int G = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_writer_if bus ();
  rtc_bus_writer_if bus2 ();

`ifdef RTC_WR_CNT_EN
  logic [7:0] n_wr;
  logic [7:0] n_wr2;
`endif

  rtc_bus_writer #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_GAP(G), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef RTC_WR_CNT_EN
    ,.n_escrituras (n_wr)
`endif
  );

  rtc_bus_writer #(.T_SETUP(2), .T_PULSE(0), .T_HOLD(2), .T_GAP(0), .CNT_W(4)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus2)
`ifdef RTC_WR_CNT_EN
    ,.n_escrituras (n_wr2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model: one queue entry per bus cycle -------
  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       a_d;
    logic       ad_oe;
    logic       done;
    logic [7:0] ad;
  } exp_t;

  exp_t q[$];

  function automatic int eff(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  task automatic push_n(input int n, input exp_t e);
    for (int i = 0; i < eff(n); i++) q.push_back(e);
  endtask

  task automatic build(input logic [7:0] a, input logic [7:0] d);
    push_n(S, '{cs_n:1'b0, wr_n:1'b1, a_d:1'b0, ad_oe:1'b1, done:1'b0, ad:a});
    push_n(P, '{cs_n:1'b0, wr_n:1'b0, a_d:1'b0, ad_oe:1'b1, done:1'b0, ad:a});
    push_n(H, '{cs_n:1'b0, wr_n:1'b1, a_d:1'b0, ad_oe:1'b1, done:1'b0, ad:a});
    push_n(G, '{cs_n:1'b1, wr_n:1'b1, a_d:1'b0, ad_oe:1'b0, done:1'b0, ad:a});
    push_n(S, '{cs_n:1'b0, wr_n:1'b1, a_d:1'b1, ad_oe:1'b1, done:1'b0, ad:d});
    push_n(P, '{cs_n:1'b0, wr_n:1'b0, a_d:1'b1, ad_oe:1'b1, done:1'b0, ad:d});
    push_n(H, '{cs_n:1'b0, wr_n:1'b1, a_d:1'b1, ad_oe:1'b1, done:1'b0, ad:d});
    push_n(1, '{cs_n:1'b1, wr_n:1'b1, a_d:1'b0, ad_oe:1'b0, done:1'b1, ad:d});
  endtask

  // Model advance: idle accepts a request, otherwise consume one cycle
  always @(posedge clk or posedge reset) begin
    if (reset) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (bus.escriba === 1'b1) build(bus.direc, bus.dato);
  end

  // Compare DUT against model every cycle outside reset
  logic       chk_en = 1'b0;
  exp_t       m_e;
  logic [6:0] m_av, m_ev;
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      m_av = {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, bus.busy, bus.siga};
      if (q.size() == 0) begin
        m_ev = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, bus.escriba};
      end else begin
        m_e  = q[0];
        m_ev = {m_e.cs_n, 1'b1, m_e.wr_n, m_e.a_d, m_e.ad_oe, 1'b1, ~m_e.done};
        if (m_e.ad_oe) check("model_ad_out", bus.ad_out, m_e.ad);
      end
      check("model_ctl{cs,rd,wr,ad,oe,busy,siga}", m_av, m_ev);
    end
  end

  // Bus monitor: record {a_d, ad_out} at every write strobe fall; count DONEs
  logic [8:0] obs[$];
  logic       prev_wr = 1'b1;
  int         n_done = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_wr && !bus.wr_n) obs.push_back({bus.a_d, bus.ad_out});
      if (!bus.siga && bus.busy) n_done++;
    end
    prev_wr = bus.wr_n;
  end

  // Drive one request and measure the transfer on the selected instance
  task automatic measure(input bit use2, input logic [7:0] a, input logic [7:0] d,
                         output int siga_hi, output int bsy_hi, output int wl_a,
                         output int wl_d, output int gap, output int bad_ad,
                         output bit done_seen);
    logic s_siga, s_busy, s_wr, s_ad, s_cs;
    logic [7:0] s_out;
    siga_hi = 0; bsy_hi = 0; wl_a = 0; wl_d = 0; gap = 0; bad_ad = 0; done_seen = 0;
    @(posedge clk); #1;
    if (use2) begin bus2.escriba = 1'b1; bus2.direc = a; bus2.dato = d; end
    else      begin bus.escriba  = 1'b1; bus.direc  = a; bus.dato  = d; end
    for (int c = 0; c < 60 && !done_seen; c++) begin
      @(negedge clk);
      s_siga = use2 ? bus2.siga   : bus.siga;
      s_busy = use2 ? bus2.busy   : bus.busy;
      s_wr   = use2 ? bus2.wr_n   : bus.wr_n;
      s_ad   = use2 ? bus2.a_d    : bus.a_d;
      s_cs   = use2 ? bus2.cs_n   : bus.cs_n;
      s_out  = use2 ? bus2.ad_out : bus.ad_out;
      if (s_siga) siga_hi++; else done_seen = 1'b1;
      if (s_siga && s_busy) bsy_hi++;
      if (!s_wr && !s_ad) wl_a++;
      if (!s_wr && s_ad) wl_d++;
      if (s_cs && s_busy && s_siga) gap++;
      if (!s_cs && !s_ad && s_out !== a) bad_ad++;
      if (!s_cs && s_ad && s_out !== d) bad_ad++;
    end
    @(posedge clk); #1;
    if (use2) bus2.escriba = 1'b0; else bus.escriba = 1'b0;
  endtask

  logic [7:0] pa [16] = '{8'h02, 8'h10, 8'h00, 8'h3A, 8'h55, 8'hAA, 8'h01, 8'h7F,
                          8'h80, 8'hFF, 8'h20, 8'h44, 8'h5C, 8'h91, 8'hC3, 8'hF0};
  logic [7:0] pd [16] = '{8'h10, 8'hD2, 8'h00, 8'h5B, 8'hAA, 8'h55, 8'hFE, 8'h80,
                          8'h7F, 8'h01, 8'h3C, 8'hC3, 8'h99, 8'h66, 8'h0F, 8'h00};

  int siga_hi, bsy_hi, wl_a, wl_d, gap, bad_ad, idx, bad, cnt;
  bit done_seen, found, seen_low;

  initial begin
    reset = 1'b1;
    bus.escriba  = 1'b0; bus.direc  = 8'h00; bus.dato  = 8'h00;
    bus2.escriba = 1'b0; bus2.direc = 8'h00; bus2.dato = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("reset_ctl{cs,rd,wr,ad,oe,busy,siga}",
          {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, bus.busy, bus.siga}, 7'b1110000);
    check("reset_ad_out", bus.ad_out, 8'h00);
    check("reset_ctl_dut2", {bus2.cs_n, bus2.wr_n, bus2.ad_oe, bus2.busy}, 4'b1100);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single write 0x02/0x10 with default timing
    measure(1'b0, 8'h02, 8'h10, siga_hi, bsy_hi, wl_a, wl_d, gap, bad_ad, done_seen);
    check("single_done_seen", done_seen, 1);
    check("single_siga_high_cycles", siga_hi, 20);
    check("single_accept_to_done", bsy_hi, 19);
    check("single_wr_low_addr", wl_a, 4);
    check("single_wr_low_data", wl_d, 4);
    check("single_gap_cycles", gap, 3);
    check("single_ad_values_bad", bad_ad, 0);
    @(negedge clk);
    check("single_idle_after", {bus.siga, bus.busy}, 2'b00);

    // Sequencer model: 16 back-to-back pairs
    obs.delete();
    n_done = 0;
    idx = 0;
    @(posedge clk); #1;
    bus.escriba = 1'b1; bus.direc = pa[0]; bus.dato = pd[0];
    for (int c = 0; c < 16 * 21 + 60 && idx < 16; c++) begin
      @(negedge clk);
      if (!bus.siga && bus.busy) begin
        idx++;
        @(posedge clk); #1;
        if (idx < 16) begin bus.direc = pa[idx]; bus.dato = pd[idx]; end
        else bus.escriba = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("seq_pairs_done", idx, 16);
    check("seq_siga_low_done_count", n_done, 16);
    check("seq_strobes_observed", obs.size(), 32);
    bad = 0;
    for (int k = 0; k < 16 && 2 * k + 1 < obs.size(); k++) begin
      if (obs[2*k]   !== {1'b0, pa[k]}) bad++;
      if (obs[2*k+1] !== {1'b1, pd[k]}) bad++;
    end
    check("seq_order_bad", bad, 0);

    // Reset during data strobe
    @(posedge clk); #1;
    bus.escriba = 1'b1; bus.direc = 8'h5A; bus.dato = 8'hA5;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.a_d && !bus.wr_n) found = 1'b1;
    end
    check("rst_reached_d_strobe", found, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_abort{wr,cs,oe,busy}", {bus.wr_n, bus.cs_n, bus.ad_oe, bus.busy}, 4'b1100);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle_siga", {bus.siga, bus.busy}, 2'b10);
    @(negedge clk);
    check("rst_fresh_a_setup{cs,wr,ad,oe}", {bus.cs_n, bus.wr_n, bus.a_d, bus.ad_oe}, 4'b0101);
    check("rst_fresh_addr", bus.ad_out, 8'h5A);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (!bus.siga && bus.busy) found = 1'b1;
    end
    check("rst_fresh_done", found, 1);
    @(posedge clk); #1;
    bus.escriba = 1'b0;

    // Request dropped during address hold
    @(posedge clk); #1;
    bus.escriba = 1'b1; bus.direc = 8'h33; bus.dato = 8'hCC;
    found = 1'b0; seen_low = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (!bus.wr_n) seen_low = 1'b1;
      else if (seen_low && !bus.a_d && !bus.cs_n) found = 1'b1;
    end
    check("drop_reached_a_hold", found, 1);
    @(posedge clk); #1;
    bus.escriba = 1'b0;
    wl_d = 0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (!bus.wr_n && bus.a_d) wl_d++;
      if (!bus.siga && bus.busy) found = 1'b1;
    end
    check("drop_done_reached", found, 1);
    check("drop_data_strobe_cycles", wl_d, 4);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.siga !== 1'b0 || bus.busy !== 1'b0 || bus.cs_n !== 1'b1) bad++;
    end
    check("drop_idle_stays_bad", bad, 0);

    // Zero-length pulse and gap instance
    measure(1'b1, 8'h21, 8'h43, siga_hi, bsy_hi, wl_a, wl_d, gap, bad_ad, done_seen);
    check("zero_done_seen", done_seen, 1);
    check("zero_accept_to_done", bsy_hi, 11);
    check("zero_wr_low_addr", wl_a, 1);
    check("zero_wr_low_data", wl_d, 1);
    check("zero_gap_cycles", gap, 1);
    check("zero_ad_values_bad", bad_ad, 0);

`ifdef RTC_WR_CNT_EN
    // Write counter wraps after 0xFF
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("cnt_reset", n_wr, 8'h00);
    bus.escriba = 1'b1; bus.direc = 8'h11; bus.dato = 8'h22;
    cnt = 0;
    for (int c = 0; c < 257 * 21 + 100 && cnt < 257; c++) begin
      @(negedge clk);
      if (!bus.siga && bus.busy) begin
        cnt++;
        if (cnt == 256) check("cnt_at_256th_done", n_wr, 8'hFF);
      end
    end
    @(posedge clk); #1;
    bus.escriba = 1'b0;
    repeat (2) @(negedge clk);
    check("cnt_done_count", cnt, 257);
    check("cnt_final", n_wr, 8'h01);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_bus_writer.md
Name: rtc_bus_writer

Overview:
- Bus-cycle engine directly downstream of the RTC initialisation sequencer.
- Consumes the address/data pair and the `escriba` request level. Executes one multiplexed address/data write cycle on the RTC parallel bus.
- Returns the `siga` advance handshake: low means the sequencer may load its next pair.
- Also reused later by the runtime time-set logic. Write-only; `rd_n` is held inactive.

Parameters:
- T_SETUP, 2, cycles a_d/ad_out are stable with cs_n low before wr_n falls.
- T_PULSE, 4, cycles wr_n is held low per phase.
- T_HOLD, 2, cycles ad_out is held after wr_n rises.
- T_GAP, 3, cycles cs_n is high between the address phase and the data phase.
- CNT_W, 4, width of the phase counter. Every T_* value must be ≤ 2^CNT_W-1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- escriba, input, 1, write-request level from the sequencer.
- direc, input, 8, RTC register address.
- dato, input, 8, data to write.
- siga, output, 1, 1 = busy/hold, 0 = sequencer may advance.
- cs_n, output, 1, chip select, active low.
- rd_n, output, 1, read strobe, constant 1.
- wr_n, output, 1, write strobe, active low.
- a_d, output, 1, 0 = address phase, 1 = data phase.
- ad_out, output, 8, multiplexed AD bus value.
- ad_oe, output, 1, AD bus output enable (tri-state buffer lives at top level).
- busy, output, 1, 1 in any state other than IDLE.

Behaviour:
- Reset: state = IDLE. Outputs: cs_n=1, rd_n=1, wr_n=1, a_d=0, ad_out=0x00, ad_oe=0, busy=0.
- Asynchronous reset aborts any cycle immediately and returns all outputs to these values.
- All bus outputs are registered. `siga` is combinational:
  - in IDLE, siga = escriba;
  - in DONE, siga = 0;
  - in all other states, siga = 1.
- States and transitions:
  - IDLE: if escriba=1, latch direc/dato into internal registers, load the counter, go to A_SETUP. The latched values are used for the whole transaction.
  - A_SETUP: cs_n=0, a_d=0, ad_oe=1, ad_out=addr, for T_SETUP cycles, then go to A_STROBE.
  - A_STROBE: as A_SETUP but wr_n=0, for T_PULSE cycles.
  - A_HOLD: wr_n=1, for T_HOLD cycles.
  - GAP: cs_n=1, ad_oe=0, for T_GAP cycles.
  - D_SETUP: cs_n=0, a_d=1, ad_oe=1, ad_out=data, for T_SETUP cycles.
  - D_STROBE: wr_n=0, for T_PULSE cycles.
  - D_HOLD: wr_n=1, for T_HOLD cycles.
  - DONE: cs_n=1, ad_oe=0, a_d=0, exactly 1 cycle, then go to IDLE.
- Phase timing:
  - A parameter value N gives exactly N cycles in that state; N=0 is treated as 1.
  - The down-counter reloads on every state entry.
- Latency, with defaults:
  - accept edge to DONE entry = 2*(S+P+H)+G = 19 cycles;
  - siga is high 20 cycles per transfer, then low for 1 cycle.
- Back-to-back transfers:
  - The sequencer loads its next pair on the DONE edge.
  - The writer is in IDLE the following cycle. If escriba=1 there, siga stays 1 and the new pair is accepted with no dead cycle.
- If escriba falls mid-transaction, the transaction completes normally. The writer then sits in IDLE with siga=0.
- direc/dato changes after accept are ignored until the next IDLE.
- Undefined or illegal state encoding goes to IDLE.

Optional Feature:
- Macro: RTC_WR_CNT_EN.
- Defined:
  - Adds output n_escrituras[7:0], reset 0.
  - Increments by 1 on every DONE cycle and wraps 255 → 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package rtc_bus_pkg holds:
  - the state enum (IDLE…DONE, 4-bit encoding);
  - default timing constants T_SETUP_D, T_PULSE_D, T_HOLD_D, T_GAP_D;
  - the AD width constant 8.
- Sub-module rtc_phase_timer: loadable down-counter of CNT_W bits.
  - Inputs: load, value (0 maps to 1).
  - Output: expire, a 1-cycle pulse on the last cycle of the phase.

Test Plan:
- Single write with defaults, escriba=1, direc=0x02, dato=0x10:
  - ad_out=0x02 while a_d=0 and cs_n=0;
  - wr_n low 4 cycles in each phase;
  - ad_out=0x10 while a_d=1;
  - cs_n high 3 cycles in GAP;
  - siga=0 exactly 1 cycle, 20 cycles after accept.
- Behavioural sequencer model driving 16 pairs (0x02/0x10, 0x10/0xD2, 0x00/0x00, …, 0xF0/0x00):
  - all 16 bus transactions observed in order with correct addr/data;
  - no pair skipped or duplicated;
  - siga low exactly 16 times.
- Reset asserted during D_STROBE:
  - same cycle: wr_n=1, cs_n=1, ad_oe=0, busy=0;
  - after release with escriba=1: a fresh transaction starts from A_SETUP.
- escriba dropped during A_HOLD:
  - data phase still completes;
  - then IDLE with siga=0, and no new transaction while escriba=0.
- T_PULSE=0, T_GAP=0 build: wr_n low exactly 1 cycle per phase, GAP lasts 1 cycle, total 2*(2+1+2)+1 = 11 cycles to DONE.
- RTC_WR_CNT_EN defined, 257 transfers: n_escrituras ends at 0x01, wrapping after 0xFF.
